// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings, latency
// defaults and the start-decode helper also used by the controller and hazard unit.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mdu_op_e;

   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;

   function automatic logic is_mdu_start(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: maps (op, a, b) to a 64-bit {hi,lo}
// result; valid is low for divide-by-zero and for non-arithmetic ops.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        valid
);

   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic [31:0]        b_safe;
   logic [31:0]        a_mag;
   logic [31:0]        b_mag;
   logic [31:0]        q_mag;
   logic [31:0]        r_mag;
   logic [31:0]        q_s;
   logic [31:0]        r_s;

   assign a_sx   = {{32{a[31]}}, a};
   assign b_sx   = {{32{b[31]}}, b};
   assign b_safe = (b == 32'd0) ? 32'd1 : b;

   // Signed division works on magnitudes; 0x80000000 / -1 then wraps to
   // quotient 0x80000000, remainder 0 without a dedicated case.
   assign a_mag = a[31] ? (~a + 32'd1) : a;
   assign b_mag = b[31] ? (~b_safe + 32'd1) : b_safe;
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
   assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case statement can infer a latch.
   always_comb begin
      result = 64'd0;
      valid  = 1'b0;
      case (op)
         OP_MULT: begin
            result = a_sx * b_sx;
            valid  = 1'b1;
         end
         OP_MULTU: begin
            result = {32'd0, a} * {32'd0, b};
            valid  = 1'b1;
         end
         OP_DIV: begin
            result = {r_s, q_s};
            valid  = (b != 32'd0);
         end
         OP_DIVU: begin
            result = {a % b_safe, a / b_safe};
            valid  = (b != 32'd0);
         end
         default: begin
            result = 64'd0;
            valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, latches operands on start and
// holds busy for a fixed MIPS-like latency before committing the result.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mduA,
   input  logic [31:0] mduB,
   input  logic [3:0]  mduOp,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mduOut
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic [63:0]      calc_result;
   logic             calc_valid;

   mdu_calc u_calc (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (calc_result),
      .valid  (calc_valid)
   );

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (busy_q) begin
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            cnt_d  = '0;
            if (calc_valid) begin
               {hi_d, lo_d} = calc_result;
            end
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (start && is_mdu_start(mduOp)) begin
         op_d   = mduOp;
         a_d    = mduA;
         b_d    = mduB;
         busy_d = 1'b1;
         cnt_d  = is_div_op(mduOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (!start) begin
         if (mduOp == OP_MTHI) hi_d = mduA;
         if (mduOp == OP_MTLO) lo_d = mduA;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         op_q   <= OP_NONE;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   always_comb begin
      mduOut = 32'd0;
      if (mduOp == OP_MFHI) mduOut = hi_q;
      if (mduOp == OP_MFLO) mduOut = lo_q;
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed scenarios plus randomized traffic, all compared
// against a cycle-level reference model built from plain 64-bit arithmetic.
module tb_mdu;
   import mdu_pkg::*;

   localparam int N_MULT = 5;
   localparam int N_DIV  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] mduA;
   logic [31:0] mduB;
   logic [3:0]  mduOp;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mduOut;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_hi, m_lo;
   int          m_rem;
   logic        m_pend_v;
   logic [63:0] m_pend;

   mdu #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
      .clk    (clk),
      .reset  (reset),
      .mduA   (mduA),
      .mduB   (mduB),
      .mduOp  (mduOp),
      .start  (start),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo),
      .mduOut (mduOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic v, output logic [63:0] r);
      longint          sa, sb, q, rm;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      v  = 1'b1;
      r  = 64'd0;
      case (op)
         OP_MULT:  r = sa * sb;
         OP_MULTU: r = ua * ub;
         OP_DIV: begin
            if (b == 0) v = 1'b0;
            else begin
               q  = sa / sb;
               rm = sa % sb;
               r  = {rm[31:0], q[31:0]};
            end
         end
         OP_DIVU: begin
            if (b == 0) v = 1'b0;
            else begin
               q  = longint'(ua / ub);
               rm = longint'(ua % ub);
               r  = {rm[31:0], q[31:0]};
            end
         end
         default: v = 1'b0;
      endcase
   endfunction

   function automatic logic m_is_start(input logic [3:0] op);
      return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
   endfunction

   function automatic void model_step(input logic rst, input logic [3:0] op,
                                      input logic [31:0] a, input logic [31:0] b, input logic st);
      if (rst) begin
         m_hi = 0; m_lo = 0; m_rem = 0; m_pend_v = 0; m_pend = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && m_pend_v) {m_hi, m_lo} = m_pend;
      end else if (st && m_is_start(op)) begin
         ref_calc(op, a, b, m_pend_v, m_pend);
         m_rem = (op == OP_DIV || op == OP_DIVU) ? N_DIV : N_MULT;
      end else if (!st) begin
         if (op == OP_MTHI) m_hi = a;
         if (op == OP_MTLO) m_lo = a;
      end
   endfunction

   // Drive one cycle of inputs, check the combinational read, clock, then
   // compare registered state against the model.
   task automatic cycle(input logic rst, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic st);
      logic [31:0] exp_out;
      reset = rst; mduOp = op; mduA = a; mduB = b; start = st;
      #1;
      exp_out = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
      check("mduOut", mduOut, exp_out);
      @(posedge clk);
      model_step(rst, op, a, b, st);
      #1;
      check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
      cycle(1'b0, op, a, b, 1'b1);
      idle(n);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      logic        rst, st;
      m_hi = 0; m_lo = 0; m_rem = 0; m_pend_v = 0; m_pend = 0;
      reset = 1'b1; mduA = 0; mduB = 0; mduOp = OP_NONE; start = 1'b0;

      // reset state
      cycle(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, OP_NONE, 32'd0, 32'd0, 1'b0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      // reset aborts an in-flight mult
      cycle(1'b0, OP_MULT, 32'd3, 32'd4, 1'b1);
      idle(1);
      cycle(1'b1, OP_NONE, 32'd0, 32'd0, 1'b0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_lo", lo, 32'd0);
      idle(N_MULT);
      check("abort_lo_later", lo, 32'd0);

      // mult: busy exactly N_MULT cycles
      cycle(1'b0, OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
      for (int i = 0; i < N_MULT - 1; i++) begin
         check("mult_busy_hi", {31'd0, busy}, 32'd1);
         idle(1);
      end
      check("mult_busy_last", {31'd0, busy}, 32'd1);
      idle(1);
      check("mult_busy_done", {31'd0, busy}, 32'd0);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFE);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, N_MULT);
      check("multu_hi", hi, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, N_DIV);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, N_DIV);
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'd0);

      // divide by zero leaves HI/LO alone
      cycle(1'b0, OP_MTHI, 32'h11, 32'd0, 1'b0);
      cycle(1'b0, OP_MTLO, 32'h22, 32'd0, 1'b0);
      cycle(1'b0, OP_DIVU, 32'd5, 32'd0, 1'b1);
      idle(N_DIV - 1);
      check("dz_busy_last", {31'd0, busy}, 32'd1);
      idle(1);
      check("dz_busy_done", {31'd0, busy}, 32'd0);
      check("dz_hi", hi, 32'h11);
      check("dz_lo", lo, 32'h22);

      // moves and reads
      cycle(1'b0, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
      check("mthi_hi", hi, 32'hDEAD_BEEF);
      reset = 1'b0; mduOp = OP_MFHI; start = 1'b0; #1;
      check("mfhi_out", mduOut, 32'hDEAD_BEEF);
      mduOp = OP_MFLO; #1;
      check("mflo_out", mduOut, 32'h22);
      @(posedge clk); #1;
      cycle(1'b0, OP_MULT, 32'd2, 32'd3, 1'b1);
      cycle(1'b0, OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
      check("mthi_busy_hi", hi, 32'hDEAD_BEEF);
      idle(N_MULT);
      check("mthi_busy_final", hi, 32'd0);

      // back-to-back: start during busy is ignored, next start on first idle cycle
      cycle(1'b0, OP_DIV, 32'd100, 32'd7, 1'b1);
      idle(2);
      $display("note: start pulse while busy, expected to be ignored");
      cycle(1'b0, OP_MULTU, 32'd9, 32'd9, 1'b1);
      for (int i = 0; i < 20 && busy; i++) idle(1);
      check("b2b_idle", {31'd0, busy}, 32'd0);
      check("b2b_div_lo", lo, 32'd14);
      check("b2b_div_hi", hi, 32'd2);
      run_op(OP_MULT, 32'd6, 32'd7, N_MULT);
      check("b2b_mult_lo", lo, 32'd42);
      check("b2b_mult_hi", hi, 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rop = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'($urandom_range(0, 3));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 3));
            default: rb = $urandom;
         endcase
         st  = m_is_start(rop) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 99) == 0);
         cycle(rst, rop, ra, rb, st);
      end
      idle(N_DIV + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
